// File: rtl/encrypt_arbiter.sv
// Round-robin share of one encrypt core between requesters A and B.
// Optional grant counters: define ENCRYPT_ARB_STATS_EN.
module encrypt_arbiter #(
  parameter int CORE_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req_a,
  input  logic [1:0] sel_a,
  input  logic [7:0] data_a,
  output logic       gnt_a,
  input  logic       req_b,
  input  logic [1:0] sel_b,
  input  logic [7:0] data_b,
  output logic       gnt_b,
  output logic [1:0] core_select,
  output logic [7:0] core_data,
  input  logic [7:0] core_en_data,
`ifdef ENCRYPT_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] cnt_a,
  output logic [15:0] cnt_b,
`endif
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_id,
  input  logic       out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TL = CORE_LAT + 1;

  logic          last_grant;
  logic          grant;
  logic [TL-1:0] tag_v;
  logic [TL-1:0] tag_id;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   fifo_count;
  logic [7:0]    mem_data [FIFO_DEPTH];
  logic          mem_id   [FIFO_DEPTH];
  logic [15:0]   occ;
  logic          space;
  logic          push;
  logic          pop;
  logic          empty;

  // Credit covers bytes in the core plus bytes queued.
  always_comb begin
    occ = 16'(fifo_count);
    for (int i = 0; i < TL; i++) begin
      occ = occ + 16'(tag_v[i]);
    end
  end

  assign space = n_rst && (occ < 16'(FIFO_DEPTH));

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      !space: begin
      end
      space && req_a && req_b: begin
        gnt_a = last_grant;
        gnt_b = !last_grant;
      end
      space && req_a && !req_b: gnt_a = 1'b1;
      space && !req_a && req_b: gnt_b = 1'b1;
      default: begin
      end
    endcase
  end

  assign grant = gnt_a | gnt_b;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      core_select <= 2'd0;
      core_data   <= 8'd0;
      last_grant  <= 1'b1;
    end else if (grant) begin
      core_select <= gnt_b ? sel_b : sel_a;
      core_data   <= gnt_b ? data_b : data_a;
      last_grant  <= gnt_b;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[TL-2:0], grant};
      tag_id <= {tag_id[TL-2:0], gnt_b};
    end
  end

  assign push       = tag_v[TL-1];
  assign empty      = (wr_ptr == rd_ptr);
  assign fifo_count = wr_ptr - rd_ptr;
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= core_en_data;
      mem_id[wr_ptr[AW-1:0]]   <= tag_id[TL-1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign out_data = out_valid ? mem_data[rd_ptr[AW-1:0]] : 8'h00;
  assign out_id   = out_valid ? mem_id[rd_ptr[AW-1:0]] : 1'b0;

`ifdef ENCRYPT_ARB_STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_a <= 16'd0;
      cnt_b <= 16'd0;
    end else if (stats_clr) begin
      cnt_a <= 16'd0;
      cnt_b <= 16'd0;
    end else begin
      if (gnt_a && cnt_a != 16'hFFFF) cnt_a <= cnt_a + 16'd1;
      if (gnt_b && cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_encrypt_arbiter.sv
// Bench for encrypt_arbiter: credit/queue model plus directed vectors.
// Stats checks compile in when ENCRYPT_ARB_STATS_EN is defined.
module tb_encrypt_arbiter;

  logic       tb_clk = 1'b0;
  logic       n_rst;
  logic       req_a, req_b, gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b, core_select;
  logic [7:0] data_a, data_b, core_data, core_en_data;
  logic       out_valid, out_id, out_ready;
  logic [7:0] out_data;
`ifdef ENCRYPT_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] cnt_a, cnt_b;
`endif

  always #5 tb_clk = ~tb_clk;

  encrypt_arbiter dut (
    .clk(tb_clk), .n_rst(n_rst),
    .req_a(req_a), .sel_a(sel_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .sel_b(sel_b), .data_b(data_b), .gnt_b(gnt_b),
    .core_select(core_select), .core_data(core_data),
    .core_en_data(core_en_data),
`ifdef ENCRYPT_ARB_STATS_EN
    .stats_clr(stats_clr), .cnt_a(cnt_a), .cnt_b(cnt_b),
`endif
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready)
  );

  // Core stub: one registered stage.
  always @(posedge tb_clk)
    core_en_data <= core_data ^ {6'b0, core_select};

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       id;
    logic [7:0] d;
    int         rdy;
  } item_t;

  item_t       q[$];
  int          outstanding = 0;
  int          cyc = 0;
  logic        m_last = 1'b1;
  logic [1:0]  m_sel = 2'd0;
  logic [7:0]  m_dat = 8'd0;
  logic [15:0] m_ca = 16'd0;
  logic [15:0] m_cb = 16'd0;

  // Model: a byte granted in cycle c is visible from cycle c+3;
  // grants allowed while granted-minus-popped < 4.
  always @(negedge tb_clk) begin : cmp
    logic ea, eb, ev, eid;
    logic [7:0] ed;
    ea = 1'b0; eb = 1'b0; ev = 1'b0; eid = 1'b0; ed = 8'd0;
    if (!n_rst) begin
      q.delete();
      outstanding = 0;
      m_last = 1'b1;
      m_sel = 2'd0;
      m_dat = 8'd0;
      m_ca = 16'd0;
      m_cb = 16'd0;
    end else begin
      if (outstanding < 4) begin
        if (req_a && req_b) begin
          ea = m_last;
          eb = !m_last;
        end else begin
          ea = req_a;
          eb = req_b;
        end
      end
      if (q.size() > 0) ev = (q[0].rdy <= cyc);
      if (ev) begin
        ed = q[0].d;
        eid = q[0].id;
      end
    end
    chk("gnt_a", 32'(gnt_a), 32'(ea));
    chk("gnt_b", 32'(gnt_b), 32'(eb));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("core_select", 32'(core_select), 32'(m_sel));
    chk("core_data", 32'(core_data), 32'(m_dat));
    if (ev) begin
      chk("out_data", 32'(out_data), 32'(ed));
      chk("out_id", 32'(out_id), 32'(eid));
    end
`ifdef ENCRYPT_ARB_STATS_EN
    chk("cnt_a", 32'(cnt_a), 32'(m_ca));
    chk("cnt_b", 32'(cnt_b), 32'(m_cb));
`endif
    if (n_rst) begin
      if (ev && out_ready) begin
        void'(q.pop_front());
        outstanding--;
      end
      if (ea) begin
        q.push_back('{1'b0, data_a ^ {6'b0, sel_a}, cyc + 3});
        outstanding++;
        m_last = 1'b0;
        m_sel = sel_a;
        m_dat = data_a;
      end
      if (eb) begin
        q.push_back('{1'b1, data_b ^ {6'b0, sel_b}, cyc + 3});
        outstanding++;
        m_last = 1'b1;
        m_sel = sel_b;
        m_dat = data_b;
      end
`ifdef ENCRYPT_ARB_STATS_EN
      if (stats_clr) begin
        m_ca = 16'd0;
        m_cb = 16'd0;
      end else begin
        if (ea && m_ca != 16'hFFFF) m_ca = m_ca + 16'd1;
        if (eb && m_cb != 16'hFFFF) m_cb = m_cb + 16'd1;
      end
`endif
    end
    cyc++;
  end

  task automatic step;
    @(posedge tb_clk);
    #1;
  endtask

  int gcount;

  initial begin
    n_rst = 1'b0;
    req_a = 1'b1; sel_a = 2'd0; data_a = 8'd0;
    req_b = 1'b0; sel_b = 2'd0; data_b = 8'd0;
    out_ready = 1'b0;
`ifdef ENCRYPT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    step; step;
    @(negedge tb_clk);
    chk("rst_gnt_a", 32'(gnt_a), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_core_sel", 32'(core_select), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    step;
    n_rst = 1'b1; req_a = 1'b0; out_ready = 1'b1;
    step;

    // Single request from A
    req_a = 1'b1; sel_a = 2'b01; data_a = 8'h75;
    @(negedge tb_clk) chk("single_gnt", 32'(gnt_a), 32'h1);
    step; req_a = 1'b0;
    @(negedge tb_clk) chk("single_gnt_once", 32'(gnt_a), 32'h0);
    step;
    @(negedge tb_clk) chk("single_t2", 32'(out_valid), 32'h0);
    step;
    @(negedge tb_clk);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data", 32'(out_data), 32'h74);
    chk("single_id", 32'(out_id), 32'h0);
    repeat (2) step;

    // Tie round-robin from a fresh reset
    n_rst = 1'b0;
    step;
    n_rst = 1'b1;
    req_a = 1'b1; sel_a = 2'b10; data_a = 8'hAA;
    req_b = 1'b1; sel_b = 2'b11; data_b = 8'h55;
    for (int i = 0; i < 6; i++) begin
      @(negedge tb_clk);
      if (i < 4)
        chk("tie_gnt", {30'd0, gnt_b, gnt_a},
            (i % 2 == 1) ? 32'h2 : 32'h1);
      if (i == 3) begin
        chk("tie_out0", {23'd0, out_id, out_data}, 32'h0A8);
      end
      if (i == 4) begin
        chk("tie_out1", {23'd0, out_id, out_data}, 32'h156);
      end
      step;
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (8) step;

    // Backpressure: credit stops grants at four outstanding
    out_ready = 1'b0;
    req_a = 1'b1; sel_a = 2'b00; data_a = 8'h54;
    gcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge tb_clk) gcount += int'(gnt_a);
      step;
    end
    chk("bp_grants", 32'(gcount), 32'd4);
    out_ready = 1'b1;
    @(negedge tb_clk);
    chk("bp_pop_data", 32'(out_data), 32'h54);
    chk("bp_full", 32'(gnt_a), 32'h0);
    step;
    out_ready = 1'b0;
    @(negedge tb_clk) chk("bp_regrant", 32'(gnt_a), 32'h1);
    step;
    req_a = 1'b0; out_ready = 1'b1;
    repeat (8) step;

    // Reset with two bytes in flight and one queued
    out_ready = 1'b0;
    req_a = 1'b1; sel_a = 2'b10; data_a = 8'h33;
    repeat (3) step;
    req_a = 1'b0;
    chk("mid_queued", 32'(out_valid), 32'h1);
    n_rst = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_core_sel", 32'(core_select), 32'h0);
    chk("mid_core_data", 32'(core_data), 32'h0);
    step;
    n_rst = 1'b1;
    req_b = 1'b1; sel_b = 2'b01; data_b = 8'h10;
    @(negedge tb_clk) chk("mid_b_first", {30'd0, gnt_b, gnt_a}, 32'h2);
    step;
    req_a = 1'b1;
    @(negedge tb_clk) chk("mid_tie_a", {30'd0, gnt_b, gnt_a}, 32'h1);
    step;
    req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
    repeat (8) step;

`ifdef ENCRYPT_ARB_STATS_EN
    n_rst = 1'b0;
    step;
    n_rst = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    repeat (4) step;
    req_b = 1'b0;
    step;
    req_a = 1'b0;
    @(negedge tb_clk);
    chk("stats_a", 32'(cnt_a), 32'd3);
    chk("stats_b", 32'(cnt_b), 32'd2);
    step;
    req_a = 1'b1; stats_clr = 1'b1;
    @(negedge tb_clk) chk("stats_clr_gnt", 32'(gnt_a), 32'h1);
    step;
    req_a = 1'b0; stats_clr = 1'b0;
    @(negedge tb_clk);
    chk("stats_clr_a", 32'(cnt_a), 32'd0);
    chk("stats_clr_b", 32'(cnt_b), 32'd0);
    repeat (6) step;
`endif

    repeat (2) step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
